// File: rtl/risc_toy_mem_arbiter.sv
// risc_toy_mem_arbiter
// Shares one single-port memory between the RISC_TOY fetch port (I) and its
// load/store port (D). Grants are combinational and same-cycle. Only one read
// is in flight at a time, and its data returns exactly RD_LAT cycles after
// the grant. Data requests beat fetch requests.
//
// Optional feature: define ARB_STARVE_GUARD_EN to add a fetch-starvation
// guard. After STARVE_LIM consecutive data grants made while a fetch was
// waiting, the fetch wins once. Without the macro, data priority is strict.

module risc_toy_mem_arbiter #(
    parameter int RD_LAT     = 2,
    parameter int STARVE_LIM = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        I_REQ,
    input  logic [29:0] I_ADDR,
    output logic        I_GNT,
    output logic        I_RVALID,
    output logic [31:0] I_RDATA,
    input  logic        D_REQ,
    input  logic        D_RW,
    input  logic [29:0] D_ADDR,
    input  logic [31:0] D_WDATA,
    output logic        D_GNT,
    output logic        D_RVALID,
    output logic [31:0] D_RDATA,
    output logic        M_REQ,
    output logic        M_RW,
    output logic [29:0] M_ADDR,
    output logic [31:0] M_WDATA,
    input  logic [31:0] M_RDATA
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic        r_ownerD;

    logic        w_open;
    logic        w_return;
    logic        w_forceI;
    logic        w_gntI;
    logic        w_gntD;
    logic        w_rdGnt;

    // Reset masks everything so that all outputs read 0 while RST is high.
    // The return cycle (counter at 0) is also an arbitration cycle.
    assign w_return = !RST && (r_state == ST_WAIT) && (r_cnt == 3'd0);
    assign w_open   = !RST && ((r_state == ST_IDLE) || (r_cnt == 3'd0));

`ifdef ARB_STARVE_GUARD_EN
    localparam int SW = $clog2(STARVE_LIM + 1);
    localparam logic [SW-1:0] LIM = SW'(STARVE_LIM);

    logic [SW-1:0] r_streak;

    assign w_forceI = (r_streak == LIM) && I_REQ && D_REQ;

    // Count data grants made while a fetch waits; any fetch grant or an open cycle without a fetch clears it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_streak <= '0;
        end else if (w_open) begin
            if (w_gntI || !I_REQ) begin
                r_streak <= '0;
            end else if (w_gntD) begin
                r_streak <= r_streak + 1'b1;
            end
        end
    end
`else
    assign w_forceI = 1'b0;
`endif

    // Data wins by default; fetch wins when it is alone or the guard forces it.
    assign w_gntI  = w_open && I_REQ && (!D_REQ || w_forceI);
    assign w_gntD  = w_open && D_REQ && !w_gntI;
    assign w_rdGnt = w_gntI || (w_gntD && !D_RW);

    // Drive the memory port from the winner and route returning read data to the owner
    always_comb begin
        I_GNT    = w_gntI;
        D_GNT    = w_gntD;
        M_REQ    = w_gntI || w_gntD;
        M_RW     = 1'b0;
        M_ADDR   = '0;
        M_WDATA  = '0;
        I_RVALID = 1'b0;
        D_RVALID = 1'b0;
        I_RDATA  = '0;
        D_RDATA  = '0;
        if (w_gntD) begin
            M_RW    = D_RW;
            M_ADDR  = D_ADDR;
            M_WDATA = D_WDATA;
        end else if (w_gntI) begin
            M_ADDR  = I_ADDR;
        end
        if (w_return) begin
            if (r_ownerD) begin
                D_RVALID = 1'b1;
                D_RDATA  = M_RDATA;
            end else begin
                I_RVALID = 1'b1;
                I_RDATA  = M_RDATA;
            end
        end
    end

    // Read-tracking FSM: a read grant (re)loads the latency countdown, and writes never leave IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 3'd0;
            r_ownerD <= 1'b0;
        end else if (w_rdGnt) begin
            r_state  <= ST_WAIT;
            r_cnt    <= LAT_LOAD;
            r_ownerD <= w_gntD;
        end else if (r_state == ST_WAIT) begin
            if (r_cnt == 3'd0) begin
                r_state <= ST_IDLE;
            end else begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

endmodule

// File: doc/risc_toy_mem_arbiter.md
# risc_toy_mem_arbiter

Shares one single-port instruction/data memory between the RISC_TOY instruction-fetch port and its load/store port. Fetch and data requests compete each cycle. The winner is driven onto the memory port, and read data is routed back with a fixed latency. The block sits between the core's IREQ/IADDR/INSTR and DREQ/DRW/DADDR/DWDATA/DRDATA pins and the memory macro. It back-pressures the core through per-port grants.

## Interface
Parameters:
- RD_LAT, 2: memory read latency in cycles, from request to M_RDATA valid. Legal range 1..7.
- STARVE_LIM, 4: maximum number of consecutive data grants while a fetch is pending (used only with the guard).

Ports:
- CLK  in  1  single clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- I_REQ  in  1  fetch request; held until granted
- I_ADDR  in  30  fetch word address
- I_GNT  out  1  fetch accepted this cycle
- I_RVALID  out  1  I_RDATA valid this cycle
- I_RDATA  out  32  fetched instruction
- D_REQ  in  1  data request; held until granted
- D_RW  in  1  1 = write, 0 = read
- D_ADDR  in  30  data word address
- D_WDATA  in  32  store data
- D_GNT  out  1  data access accepted this cycle
- D_RVALID  out  1  D_RDATA valid this cycle
- D_RDATA  out  32  load data
- M_REQ  out  1  memory access this cycle
- M_RW  out  1  memory write enable
- M_ADDR  out  30  memory word address
- M_WDATA  out  32  memory write data
- M_RDATA  in  32  memory read data, RD_LAT cycles after M_REQ

## Operation
- FSM has two states.
  - IDLE: arbitration is open.
  - WAIT: a read is outstanding. A 3-bit counter runs from RD_LAT-1 down to 0.
- Arbitration runs in IDLE, and in WAIT on the cycle the counter equals 0.
  - D_REQ wins over I_REQ by default.
  - Exactly one of I_GNT/D_GNT is high, and only if its REQ is high.
  - M_REQ = I_GNT | D_GNT.
  - M_RW, M_ADDR and M_WDATA are combinational muxes of the winner's inputs.
  - Fetch always has M_RW=0 and M_WDATA=0.
- Grant outcomes:
  - Read grant (fetch, or data with D_RW=0): FSM goes to WAIT, counter loads RD_LAT-1, and the owner (I or D) is registered.
  - Write grant: completes in the grant cycle, no RVALID, FSM stays in IDLE.
- Read return:
  - In WAIT with counter 0, X_RVALID=1 for the registered owner X.
  - X_RDATA = M_RDATA (combinational pass-through).
  - The other port's RDATA output is 0.
  - In the same cycle the FSM returns to IDLE, or reloads WAIT if a new read is granted.
- Only one read is outstanding at a time. No request is accepted in WAIT while the counter is above 0.
- When the grant is low, REQ/ADDR/WDATA changes are ignored. Requesters must hold them stable until granted.

## Timing
- Reset values: all outputs 0, FSM in IDLE, counters 0.
- RST asserted mid-read drops the in-flight read. No RVALID is produced after reset, and a late M_RDATA is ignored.
- Grant is same-cycle: a request arriving in an open cycle is granted in that cycle.
- Read latency: grant at cycle T gives RVALID at T+RD_LAT. Peak read throughput is 1 per RD_LAT cycles.
- Write occupancy: one cycle. Back-to-back writes give 1 per cycle.
- RD_LAT=1: the counter loads 0, so every cycle in WAIT is both a return and an arbitration cycle.
- Simultaneous I_REQ and D_REQ: D wins, except as given in Configuration.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - A streak counter increments on each D grant made while I_REQ=1.
  - It clears on any I grant, and on any arbitration cycle with I_REQ=0.
  - When the streak equals STARVE_LIM and both requests are high, I wins and the streak clears.
- ARB_STARVE_GUARD_EN undefined:
  - Strict data priority; fetch can starve indefinitely.
  - No streak counter is present and STARVE_LIM is unused.

## Test plan
- Reset: RST=1 for 2 cycles with I_REQ=1 → all outputs 0. First cycle after release: I_GNT=1, M_ADDR=I_ADDR.
- Fetch read, RD_LAT=2: I_ADDR=0x10 granted at T. Memory returns 0xDEADBEEF at T+2 → I_RVALID=1 and I_RDATA=0xDEADBEEF at T+2. No grant at T+1. D_RVALID=0 throughout.
- Contention: I_REQ and D_REQ high together, D_RW=1, D_ADDR=0x20, D_WDATA=0x1234.
  - Cycle T: D_GNT=1, M_RW=1, M_WDATA=0x1234.
  - Cycle T+1: I_GNT=1.
- Starvation, macro defined, STARVE_LIM=4: D_REQ writes held continuously with I_REQ=1 → four D grants, then I_GNT=1 on the fifth cycle, then D resumes. With the macro undefined, I_GNT stays 0 for 20 cycles.
- Reset mid-read: D read granted at T, RST=1 at T+1 → D_RVALID stays 0 at T+2, FSM in IDLE.
- RD_LAT=1 back-to-back: I_REQ held with addresses 0, 1, 2 → grants and RVALIDs on consecutive cycles, each RDATA matching the prior-cycle address.
